// File: rtl/count_sequencer.sv
// Sequencer for a 4-bit up-counter: paces counting with a rate divider and runs
// one-shot or wrapping count-to-Limit runs with start/pause/resume/abort control.
module count_sequencer #(
  parameter int DIV   = 4,
  parameter int DIV_W = 8
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Abort,
  input  logic       Mode,
  input  logic [3:0] Limit,
  input  logic [3:0] Cnt_Q,
  output logic       Cnt_En,
  output logic       Cnt_Clr,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Wrap_Count
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_e;

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       limit_q, limit_d;
  logic             mode_q, mode_d;
  logic [7:0]       wrap_q, wrap_d;
  logic             en_q, en_d;
  logic             clr_q, clr_d;
  logic             done_q, done_d;

  logic tick;
  logic lim_hit;

  assign tick    = (div_q == '0);
  assign lim_hit = (Cnt_Q == limit_q);

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= ST_IDLE;
      div_q   <= DIV_RELOAD;
      limit_q <= '0;
      mode_q  <= 1'b0;
      wrap_q  <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

  // Abort in IDLE is a no-op and also blocks a simultaneous Start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!Abort && Start) state_d = ST_RUN;
      ST_RUN: begin
        if (Abort)                               state_d = ST_IDLE;
        else if (Stop)                           state_d = ST_PAUSE;
        else if (tick && lim_hit && !mode_q)     state_d = ST_DONE;
      end
      ST_PAUSE: begin
        if (Abort)                 state_d = ST_IDLE;
        else if (!Stop && Start)   state_d = ST_RUN;
      end
      ST_DONE: begin
        if (Abort)      state_d = ST_IDLE;
        else if (Start) state_d = ST_RUN;
      end
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    div_d   = div_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    wrap_d  = wrap_q;
    en_d    = 1'b0;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Abort) begin
          clr_d = (state_q == ST_DONE);
        end else if (Start) begin
          limit_d = Limit;
          mode_d  = Mode;
          clr_d   = 1'b1;
          wrap_d  = '0;
          div_d   = DIV_RELOAD;
        end
      end
      ST_RUN: begin
        if (Abort) begin
          clr_d = 1'b1;
        end else if (!Stop) begin
          if (!tick) begin
            div_d = div_q - 1'b1;
          end else begin
            div_d = DIV_RELOAD;
            if (!lim_hit) begin
              en_d = 1'b1;
            end else if (!mode_q) begin
              done_d = 1'b1;
            end else begin
              clr_d = 1'b1;
              if (wrap_q != 8'hFF) wrap_d = wrap_q + 8'd1;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (Abort) clr_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign Cnt_En     = en_q;
  assign Cnt_Clr    = clr_q;
  assign Done       = done_q;
  assign Wrap_Count = wrap_q;
  assign Busy       = (state_q == ST_RUN) || (state_q == ST_PAUSE);

endmodule
